// File: rtl/sdram_wb_bridge.sv
// Bus-to-SDRAM-controller bridge: posted write buffer,
// read-after-write ordering, read capture and request timeout.
module sdram_wb_bridge #(
  parameter int ADDR_W  = 21,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_ready,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [1:0]        wb_sel,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [15:0]       wb_dat_i,
  output logic [15:0]       wb_dat_o,
  output logic              wb_ack,
  output logic              sdr_wr_req,
  output logic              sdr_rd_req,
  input  logic              sdr_wr_ack,
  input  logic              sdr_rd_ack,
  output logic [ADDR_W:0]   sdr_addr,
  output logic [15:0]       sdr_wdata,
  input  logic [15:0]       sdr_rdata,
  output logic [1:0]        sdr_be,
  output logic              dqm_h,
  output logic              dqm_l,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    IDLE, R_WAIT, R_REQ, R_CAP, HOLD
  } state_t;

  state_t state, state_nx;

  logic              wfull;
  logic [ADDR_W-1:0] buf_adr;
  logic [15:0]       buf_dat;
  logic [1:0]        buf_sel;
  logic [ADDR_W-1:0] rd_adr;
  logic [7:0]        tcnt;
  logic              rd_to;
  logic              abort;

  logic wr_load, rd_issue, wr_start;
  logic wr_done, rd_done, to_hit;
  logic cap_keep;

  assign wr_done  = sdr_wr_req & sdr_wr_ack;
  assign rd_done  = sdr_rd_req & sdr_rd_ack;
  assign to_hit   = (sdr_wr_req | sdr_rd_req)
                  & ~(wr_done | rd_done)
                  & (tcnt == 8'(TIMEOUT - 1));
  assign wr_start = wfull & sdram_ready & ~sdr_wr_req;
  assign cap_keep = wb_stb & ~abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_load  = 1'b0;
    rd_issue = 1'b0;
    unique case (state)
      IDLE: begin
        if (wb_stb && wb_we) begin
          if (!wfull && sdram_ready) begin
            wr_load  = 1'b1;
            state_nx = HOLD;
          end
        end else if (wb_stb) begin
          if (wfull || !sdram_ready) begin
            state_nx = R_WAIT;
          end else begin
            rd_issue = 1'b1;
            state_nx = R_REQ;
          end
        end
      end
      R_WAIT: begin
        if (!wb_stb) begin
          state_nx = IDLE;
        end else if (!wfull && sdram_ready) begin
          rd_issue = 1'b1;
          state_nx = R_REQ;
        end
      end
      R_REQ: begin
        if (rd_done || to_hit) state_nx = R_CAP;
      end
      R_CAP: begin
        state_nx = cap_keep ? HOLD : IDLE;
      end
      HOLD: begin
        if (!wb_stb) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Write buffer and its drain; independent of the read FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wfull      <= 1'b0;
      buf_adr    <= '0;
      buf_dat    <= '0;
      buf_sel    <= '0;
      sdr_wr_req <= 1'b0;
    end else begin
      if (wr_load) begin
        buf_adr <= wb_adr;
        buf_dat <= wb_dat_i;
        buf_sel <= wb_sel;
      end
      if (wr_load)
        wfull <= 1'b1;
      else if (wr_done || (sdr_wr_req && to_hit))
        wfull <= 1'b0;
      if (wr_load || wr_start)
        sdr_wr_req <= 1'b1;
      else if (wr_done || to_hit)
        sdr_wr_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdr_rd_req  <= 1'b0;
      rd_adr      <= '0;
      tcnt        <= '0;
      timeout_err <= 1'b0;
      rd_to       <= 1'b0;
      abort       <= 1'b0;
      wb_ack      <= 1'b0;
      wb_dat_o    <= 16'h0000;
      dqm_h       <= 1'b1;
      dqm_l       <= 1'b1;
    end else begin
      if (rd_issue) begin
        sdr_rd_req <= 1'b1;
        rd_adr     <= wb_adr;
      end else if (rd_done || to_hit) begin
        sdr_rd_req <= 1'b0;
      end

      if (rd_issue || wr_load || wr_start || wr_done
          || rd_done || to_hit)
        tcnt <= '0;
      else if (sdr_wr_req || sdr_rd_req)
        tcnt <= tcnt + 8'd1;

      if (to_hit) timeout_err <= 1'b1;

      if (rd_issue)
        rd_to <= 1'b0;
      else if (sdr_rd_req && to_hit)
        rd_to <= 1'b1;

      // A read whose master walks away still finishes on the bus.
      if (rd_issue)
        abort <= 1'b0;
      else if (state == R_REQ && !wb_stb)
        abort <= 1'b1;

      if (state == R_CAP && cap_keep)
        wb_dat_o <= rd_to ? 16'hFFFF : sdr_rdata;

      if (wr_load || (state == R_CAP && cap_keep))
        wb_ack <= 1'b1;
      else if (state == HOLD && !wb_stb)
        wb_ack <= 1'b0;

      if (wr_load) begin
        dqm_h <= ~wb_sel[1];
        dqm_l <= ~wb_sel[0];
      end else if (wr_start) begin
        dqm_h <= ~buf_sel[1];
        dqm_l <= ~buf_sel[0];
      end else if (rd_issue) begin
        dqm_h <= 1'b0;
        dqm_l <= 1'b0;
      end
    end
  end

  assign sdr_addr  = {1'b0, sdr_wr_req ? buf_adr : rd_adr};
  assign sdr_wdata = buf_dat;
  assign sdr_be    = sdr_wr_req ? buf_sel
                   : (sdr_rd_req ? 2'b11 : 2'b00);

endmodule

// File: doc/sdram_wb_bridge.md
# sdram_wb_bridge

Bus-side front end for the SDRAM path: converts the 16-bit processor-side memory bus (stb/we/sel/adr/dat/ack) into the request/acknowledge protocol of `sdram_top` and drives the SDRAM byte-mask pins. It provides a one-entry posted-write buffer, read-after-write ordering, read-data capture, per-request timeout, and gating on SDRAM initialisation. It sits between the kernel's `sdram_*` bus and the SDRAM controller instance in the board top, on the `clk_p` domain.

## Interface
- `ADDR_W`, 21: word address width (bus address bits [21:1]).
- `TIMEOUT`, 255: maximum cycles a controller request may stay pending; 8-bit counter.

- `clk`  in  1  system clock (`clk_p`); all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sdram_ready`  in  1  controller init-done; no request is issued while low.
- `wb_stb`  in  1  bus transaction strobe; held by master until `wb_ack`.
- `wb_we`  in  1  1 = write, 0 = read.
- `wb_sel`  in  2  byte enables: [1] high byte, [0] low byte.
- `wb_adr`  in  ADDR_W  word address.
- `wb_dat_i`  in  16  write data.
- `wb_dat_o`  out  16  read data, registered.
- `wb_ack`  out  1  transaction acknowledge, registered.
- `sdr_wr_req` / `sdr_rd_req`  out  1  controller write / read request.
- `sdr_wr_ack` / `sdr_rd_ack`  in  1  controller acknowledges, single-cycle pulses.
- `sdr_addr`  out  ADDR_W+1  request address, `{1'b0, adr}`.
- `sdr_wdata`  out  16  write data to controller.
- `sdr_rdata`  in  16  read data from controller; valid the cycle after `sdr_rd_ack`.
- `sdr_be`  out  2  byte enables to controller.
- `dqm_h`, `dqm_l`  out  1  SDRAM UDQM/LDQM.
- `timeout_err`  out  1  sticky; set on any request timeout.

## Operation
- Reset: all outputs 0, except `wb_dat_o` = 16'h0000 and `dqm_h`/`dqm_l` = 1. Write buffer empty. Main FSM in IDLE. Timeout counter 0. `timeout_err` 0.
- Write buffer: one entry holding `adr`, `data`, and `sel`, plus a `wfull` flag. Drain logic runs independently of the main FSM.
  - When `wfull` and `sdram_ready` are both high, assert `sdr_wr_req` and hold it until `sdr_wr_ack`.
  - On `sdr_wr_ack`: clear `wfull` and `sdr_wr_req` on the same edge.
  - While draining: `sdr_addr`, `sdr_wdata`, and `sdr_be` come from the buffer; `dqm_h = ~sel[1]`, `dqm_l = ~sel[0]`.
- Main FSM states: IDLE, R_WAIT, R_REQ, R_CAP, HOLD.
  - IDLE, `wb_stb & wb_we`: if `!wfull` and `sdram_ready`, load the buffer, set `wfull`, set `wb_ack` → HOLD. Otherwise stay in IDLE (stall).
  - IDLE, `wb_stb & !wb_we`: if `wfull` or `!sdram_ready` → R_WAIT. Otherwise assert `sdr_rd_req` with `sdr_addr = {0, wb_adr}` and `sdr_be = 2'b11` → R_REQ.
  - R_WAIT: when `!wfull & sdram_ready`, assert `sdr_rd_req` → R_REQ. This enforces read-after-write ordering: a read never overtakes a posted write.
  - R_REQ: on `sdr_rd_ack`, drop `sdr_rd_req` → R_CAP.
  - R_CAP: `wb_dat_o <= sdr_rdata`, `wb_ack <= 1` → HOLD.
  - HOLD: `wb_ack` stays high while `wb_stb` is high. When `wb_stb` is sampled low, clear `wb_ack` → IDLE.
- Reads: `dqm_h = dqm_l = 0`. DQM registers hold their last value when no request is active.
- Address mux: the buffer has priority while `sdr_wr_req` is high. `sdr_wr_req` and `sdr_rd_req` are never high in the same cycle; the ordering rule above guarantees this.
- Timeout:
  - The counter increments each cycle that `sdr_wr_req` or `sdr_rd_req` is high and clears on the matching ack.
  - When it reaches `TIMEOUT`: drop the request and set `timeout_err`.
  - Write timeout: clear `wfull`; the data is lost.
  - Read timeout: go to R_CAP with the captured data forced to 16'hFFFF.
  - `timeout_err` is cleared only by reset.
- `wb_stb` dropping mid-read, before HOLD: the controller transaction still completes. The captured data is discarded and the FSM returns to IDLE without asserting `wb_ack`.
- Reset asserted mid-operation: everything returns to reset values immediately, including `sdr_*_req` going low.

## Timing
- Posted write with buffer empty: `wb_stb` sampled at edge 0 → `wb_ack` and `sdr_wr_req` high after edge 1.
- Read, buffer empty: `sdr_rd_req` high after edge 1. If `sdr_rd_ack` is sampled at edge k: `wb_dat_o` valid and `wb_ack` high after edge k+1.
  - Minimum read latency is 3 cycles from `wb_stb` to `wb_ack`.
- Read behind a pending write: `sdr_rd_req` rises 1 cycle after the edge that samples `sdr_wr_ack`.
- Back-to-back writes: the second write is accepted no earlier than 1 cycle after the first drain's `sdr_wr_ack`.
- Single-cycle ack pulses from the controller are sufficient; acks arriving while no request is outstanding are ignored.

## Test plan
- Write `adr` 0x00100, `dat` 0x1234, `sel` 2'b10 → `wb_ack` 1 cycle later; `sdr_wr_req` with `sdr_be` 2'b10, `dqm_h` 0, `dqm_l` 1; buffer cleared on `sdr_wr_ack`.
- Read `adr` 0x00100 with the controller returning 0xBEEF 3 cycles after the request → `wb_dat_o` = 0xBEEF; `wb_ack` 2 cycles after `sdr_rd_ack`; DQM 00.
- Write, then an immediate read while the write is still draining → `sdr_rd_req` stays low until 1 cycle after `sdr_wr_ack`; never overlaps `sdr_wr_req`.
- `sdram_ready` held low for 100 cycles with `wb_stb` high → no requests and no `wb_ack`; normal completion after `sdram_ready` rises.
- Controller never acks a read → after 255 cycles, `sdr_rd_req` drops, `timeout_err` = 1, `wb_dat_o` = 0xFFFF, `wb_ack` asserted.
- `rst_n` pulsed low while `sdr_wr_req` is high → all outputs at reset values immediately; the next write is accepted normally after release.
